// File: rtl/pll_lock_sequencer.sv
// Reset/lock sequencer for the 27 MHz-referenced rPLL: pulses the PLL reset, waits for lock with
// timeout and bounded retries, qualifies stable lock, then releases sys_rst. Option: LOCK_GLITCH_FILTER_EN.
module pll_lock_sequencer #(
    parameter int RST_PULSE_CYC    = 32,
    parameter int LOCK_TIMEOUT_CYC = 270000,
    parameter int LOCK_STABLE_CYC  = 2700,
    parameter int MAX_RETRIES      = 3,
    parameter int GLITCH_CYC       = 4
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       restart,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_rst,
    output logic       pll_ready,
    output logic       pll_fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt,
    output logic [2:0] state_o
);

    localparam int MAX_AB = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
    localparam int MAX_CD = (LOCK_STABLE_CYC > GLITCH_CYC) ? LOCK_STABLE_CYC : GLITCH_CYC;
    localparam int MAX_T  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W  = $clog2(MAX_T) + 1;

    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
`ifdef LOCK_GLITCH_FILTER_EN
    localparam logic [CNT_W-1:0] GLITCH_LAST  = CNT_W'(GLITCH_CYC - 1);
`endif
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       retry_reg, retry_next;
    logic [7:0]       loss_reg, loss_next;
    logic [1:0]       sync_reg;
    logic             pll_reset_reg, sys_rst_reg, pll_ready_reg, pll_fail_reg;
    logic             lock_s;
    logic [3:0]       retry_inc;
    logic [7:0]       loss_inc;

    assign lock_s    = sync_reg[1];
    assign retry_inc = retry_reg + 4'd1;
    assign loss_inc  = (loss_reg == 8'hFF) ? loss_reg : loss_reg + 8'd1;

    // Next-state logic; the counter restarts from zero on every state change.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 1'b1;
        retry_next = retry_reg;
        loss_next  = loss_reg;
        if (restart) begin
            state_next = ST_RESET_PLL;
            cnt_next   = '0;
            retry_next = 4'd0;
        end else begin
            case (state_reg)
                ST_RESET_PLL: begin
                    if (cnt_reg == PULSE_LAST) begin
                        state_next = ST_WAIT_LOCK;
                        cnt_next   = '0;
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock seen on the timeout cycle still wins.
                    if (lock_s) begin
                        state_next = ST_STABLE;
                        cnt_next   = '0;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        retry_next = retry_inc;
                        cnt_next   = '0;
                        state_next = (retry_inc == RETRY_LIMIT) ? ST_FAIL : ST_RESET_PLL;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_next = ST_WAIT_LOCK;
                        cnt_next   = '0;
                    end else if (cnt_reg == STABLE_LAST) begin
                        state_next = ST_RUN;
                        cnt_next   = '0;
                        retry_next = 4'd0;
                    end
                end
                ST_RUN: begin
`ifdef LOCK_GLITCH_FILTER_EN
                    // In RUN the counter measures the current run of low lock samples.
                    if (lock_s) begin
                        cnt_next = '0;
                    end else if (cnt_reg == GLITCH_LAST) begin
                        state_next = ST_RESET_PLL;
                        cnt_next   = '0;
                        loss_next  = loss_inc;
                    end
`else
                    cnt_next = '0;
                    if (!lock_s) begin
                        state_next = ST_RESET_PLL;
                        loss_next  = loss_inc;
                    end
`endif
                end
                ST_FAIL: begin
                    cnt_next = '0;
                end
                default: begin
                    state_next = ST_RESET_PLL;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            sync_reg      <= 2'b00;
            state_reg     <= ST_RESET_PLL;
            cnt_reg       <= '0;
            retry_reg     <= 4'd0;
            loss_reg      <= 8'd0;
            pll_reset_reg <= 1'b1;
            sys_rst_reg   <= 1'b1;
            pll_ready_reg <= 1'b0;
            pll_fail_reg  <= 1'b0;
        end else begin
            sync_reg      <= {sync_reg[0], pll_lock};
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            retry_reg     <= retry_next;
            loss_reg      <= loss_next;
            pll_reset_reg <= (state_next == ST_RESET_PLL);
            sys_rst_reg   <= (state_next != ST_RUN);
            pll_ready_reg <= (state_next == ST_RUN);
            pll_fail_reg  <= (state_next == ST_FAIL);
        end
    end

    assign pll_reset = pll_reset_reg;
    assign sys_rst   = sys_rst_reg;
    assign pll_ready = pll_ready_reg;
    assign pll_fail  = pll_fail_reg;
    assign retry_cnt = retry_reg;
    assign loss_cnt  = loss_reg;
    assign state_o   = state_reg;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short timing parameters; expectations are
// hand-derived cycle counts. Honours LOCK_GLITCH_FILTER_EN when defined.
module tb_pll_lock_sequencer;

    localparam int RST_PULSE = 4;
    localparam int TIMEOUT   = 20;
    localparam int STABLE    = 8;
    localparam int MAXR      = 2;
    localparam int GLITCH    = 3;

`ifdef LOCK_GLITCH_FILTER_EN
    localparam int LOSS_LAT = 5;
`else
    localparam int LOSS_LAT = 3;
`endif

    logic       clkin    = 1'b0;
    logic       reset    = 1'b1;
    logic       restart  = 1'b0;
    logic       pll_lock = 1'b0;
    logic       pll_reset, sys_rst, pll_ready, pll_fail;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;
    logic [2:0] state_o;

    int checks   = 0;
    int failures = 0;

    pll_lock_sequencer #(
        .RST_PULSE_CYC   (RST_PULSE),
        .LOCK_TIMEOUT_CYC(TIMEOUT),
        .LOCK_STABLE_CYC (STABLE),
        .MAX_RETRIES     (MAXR),
        .GLITCH_CYC      (GLITCH)
    ) dut (
        .clkin    (clkin),
        .reset    (reset),
        .restart  (restart),
        .pll_lock (pll_lock),
        .pll_reset(pll_reset),
        .sys_rst  (sys_rst),
        .pll_ready(pll_ready),
        .pll_fail (pll_fail),
        .retry_cnt(retry_cnt),
        .loss_cnt (loss_cnt),
        .state_o  (state_o)
    );

    always #5 clkin = ~clkin;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_state(input logic [2:0] s, output int n);
        n = 0;
        while (state_o !== s && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (pll_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic count_reset_level(input logic lvl, output int n);
        n = 0;
        while (pll_reset === lvl && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int first;
        int hi;
        int saw;

        // Reset values
        tick();
        check("rst_state", state_o, 0);
        check("rst_pll_reset", pll_reset, 1);
        check("rst_sys_rst", sys_rst, 1);
        check("rst_ready", pll_ready, 0);
        check("rst_fail", pll_fail, 0);
        check("rst_retry", retry_cnt, 0);
        check("rst_loss", loss_cnt, 0);
        reset = 1'b0;

        // 1: lock 10 cycles after pll_reset falls
        count_reset_level(1'b1, n);
        check("t1_pulse_len", n, RST_PULSE);
        ticks(10);
        pll_lock = 1'b1;
        ticks(3);
        check("t1_state_stable", state_o, 2);
        ticks(7);
        check("t1_ready_early", pll_ready, 0);
        tick();
        check("t1_ready", pll_ready, 1);
        check("t1_sys_rst", sys_rst, 0);
        check("t1_state_run", state_o, 3);
        check("t1_retry", retry_cnt, 0);

        // 4: runtime loss, 5-cycle drop
        pll_lock = 1'b0;
        first = 0;
        hi = 0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (sys_rst === 1'b1 && first == 0) first = i;
            if (pll_reset === 1'b1) hi++;
        end
        pll_lock = 1'b1;
        n = 0;
        while (pll_reset === 1'b1 && n < 50) begin
            tick();
            n++;
            if (pll_reset === 1'b1) hi++;
        end
        check("t4_loss_latency", first, LOSS_LAT);
        check("t4_pulse_len", hi, RST_PULSE);
        check("t4_loss_cnt", loss_cnt, 1);
        wait_ready(n);
        check("t4_rerun_ready", pll_ready, 1);

        // 5: 2-cycle drop in RUN
        pll_lock = 1'b0;
        ticks(2);
        pll_lock = 1'b1;
        saw = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (sys_rst === 1'b1) saw = 1;
        end
`ifdef LOCK_GLITCH_FILTER_EN
        check("t5_short_sys_rst", saw, 0);
        check("t5_short_loss", loss_cnt, 1);
        check("t5_short_state", state_o, 3);
        pll_lock = 1'b0;
        ticks(3);
        pll_lock = 1'b1;
        ticks(3);
        check("t5_long_loss", loss_cnt, 2);
        check("t5_long_state", state_o, 0);
        check("t5_long_sys_rst", sys_rst, 1);
`else
        check("t5_short_sys_rst", saw, 1);
        check("t5_short_loss", loss_cnt, 2);
`endif
        wait_ready(n);
        check("t5_rerun_ready", pll_ready, 1);

        // 3: one-cycle drop in STABLE
        pulse_restart();
        check("t3_restart_state", state_o, 0);
        wait_state(3'd2, n);
        check("t3_to_stable", n, RST_PULSE + 1);
        ticks(4);
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        tick();
        check("t3_still_stable", state_o, 2);
        tick();
        check("t3_back_wait", state_o, 1);
        check("t3_retry", retry_cnt, 0);
        wait_ready(n);
        check("t3_fresh_stable", n, STABLE + 1);

        // 2: no lock, retries exhausted
        pll_lock = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        count_reset_level(1'b1, n);
        check("t2_pulse1", n, RST_PULSE);
        count_reset_level(1'b0, n);
        check("t2_gap", n, TIMEOUT);
        check("t2_retry1", retry_cnt, 1);
        count_reset_level(1'b1, n);
        check("t2_pulse2", n, RST_PULSE);
        n = 0;
        while (pll_fail !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("t2_to_fail", n, TIMEOUT);
        check("t2_fail_state", state_o, 4);
        check("t2_fail_retry", retry_cnt, 2);
        check("t2_fail_sys_rst", sys_rst, 1);
        check("t2_fail_pll_reset", pll_reset, 0);
        ticks(5);
        check("t2_fail_hold", state_o, 4);
        pulse_restart();
        check("t2_restart_state", state_o, 0);
        check("t2_restart_retry", retry_cnt, 0);
        check("t2_restart_fail", pll_fail, 0);
        check("t2_restart_pll_reset", pll_reset, 1);

        // 6a: async reset during STABLE
        pll_lock = 1'b1;
        wait_state(3'd2, n);
        check("t6_in_stable", state_o, 2);
        reset = 1'b1;
        #1;
        check("t6_async_state", state_o, 0);
        check("t6_async_pll_reset", pll_reset, 1);
        check("t6_async_sys_rst", sys_rst, 1);
        check("t6_async_loss", loss_cnt, 0);
        pll_lock = 1'b0;
        tick();
        reset = 1'b0;

        // 6b: restart coincident with the final timeout
        wait_state(3'd1, n);
        wait_state(3'd0, n);
        check("t6_retry1", retry_cnt, 1);
        wait_state(3'd1, n);
        ticks(TIMEOUT - 1);
        check("t6_pre_timeout", state_o, 1);
        pulse_restart();
        check("t6_restart_state", state_o, 0);
        check("t6_restart_retry", retry_cnt, 0);
        check("t6_restart_fail", pll_fail, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
